// File: rtl/issue_scheduler_pkg.sv
// Shared widths, slot record and state encoding for the issue scheduler.
// Imported by the scheduler top level and its scoreboard.
package issue_scheduler_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 17;
    localparam int REG_W = 5;
    localparam int CSR_W = 12;
    localparam int NREG  = 32;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [CSR_W-1:0] csr;
        logic [XLEN-1:0]  imm;
    } slot_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] idx);
        reg_onehot = '0;
        reg_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/issue_scheduler_sb.sv
// Register scoreboard: busy bits for pending writes plus the in-flight count.
// Exposes a writeback-bypassed busy view so a same-cycle writeback unblocks issue.
module issue_scheduler_sb
    import issue_scheduler_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_rd,
    input  logic             i_wb_valid,
    input  logic [REG_W-1:0] i_wb_rd,
    output logic [NREG-1:0]  o_busy_map,
    output logic [NREG-1:0]  o_busy_eff,
    output logic [CNT_W-1:0] o_inflight,
    output logic             o_full,
    output logic             o_wb_dec
);

    logic [NREG-1:0]  r_busy;
    logic [CNT_W-1:0] r_inflight;
    logic [NREG-1:0]  w_wb_mask;
    logic [NREG-1:0]  w_set_mask;
    logic [NREG-1:0]  w_busy_nxt;
    logic             w_set;

    always_comb begin
        w_wb_mask  = i_wb_valid ? reg_onehot(i_wb_rd) : '0;
        w_set      = i_set_en && (i_set_rd != '0);
        w_set_mask = w_set ? reg_onehot(i_set_rd) : '0;
        o_wb_dec   = i_wb_valid && (i_wb_rd != '0) && r_busy[i_wb_rd];
        o_busy_eff = r_busy & ~w_wb_mask;
        // Set after clear so a retiring and re-issuing register stays busy
        w_busy_nxt = ((r_busy & ~w_wb_mask) | w_set_mask) & ~NREG'(1);
        o_full     = (r_inflight == CNT_W'(MAX_INFLIGHT));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_busy     <= '0;
            r_inflight <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            unique case ({w_set, o_wb_dec})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign o_busy_map = r_busy;
    assign o_inflight = r_inflight;

endmodule

// File: rtl/issue_scheduler.sv
// Issue slot and handshake to execute; holds one checked instruction until
// its operands and destination are free of RAW/WAW hazards.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             FLUSH,
    input  logic             MEM_WAIT,
    input  logic             CHECK_ACCEPT,
    input  logic [XLEN-1:0]  CHECK_PC,
    input  logic [OPC_W-1:0] CHECK_OPCODE,
    input  logic [REG_W-1:0] CHECK_RD,
    input  logic [REG_W-1:0] CHECK_RS1,
    input  logic [REG_W-1:0] CHECK_RS2,
    input  logic [CSR_W-1:0] CHECK_CSR,
    input  logic [XLEN-1:0]  CHECK_IMM,
    output logic             SCHED_STALL,
    output logic             ISSUE_VALID,
    input  logic             ISSUE_READY,
    output logic [XLEN-1:0]  ISSUE_PC,
    output logic [OPC_W-1:0] ISSUE_OPCODE,
    output logic [REG_W-1:0] ISSUE_RD,
    output logic [REG_W-1:0] ISSUE_RS1,
    output logic [REG_W-1:0] ISSUE_RS2,
    output logic [CSR_W-1:0] ISSUE_CSR,
    output logic [XLEN-1:0]  ISSUE_IMM,
    input  logic             WB_VALID,
    input  logic [REG_W-1:0] WB_RD,
    output logic [NREG-1:0]  BUSY_MAP,
    output logic [CNT_W-1:0] INFLIGHT
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    slot_t            r_slot;
    slot_t            w_check;
    logic             w_capture;
    logic             w_held;
    logic             w_hazard;
    logic             w_fire;
    logic             w_full;
    logic             w_wb_dec;
    logic [NREG-1:0]  w_busy_eff;

    issue_scheduler_sb #(
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CNT_W       (CNT_W)
    ) u_sb (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_set_en  (w_fire),
        .i_set_rd  (r_slot.rd),
        .i_wb_valid(WB_VALID),
        .i_wb_rd   (WB_RD),
        .o_busy_map(BUSY_MAP),
        .o_busy_eff(w_busy_eff),
        .o_inflight(INFLIGHT),
        .o_full    (w_full),
        .o_wb_dec  (w_wb_dec)
    );

    always_comb begin
        w_check = '{pc: CHECK_PC, opcode: CHECK_OPCODE, rd: CHECK_RD,
                    rs1: CHECK_RS1, rs2: CHECK_RS2, csr: CHECK_CSR,
                    imm: CHECK_IMM};
        w_held = (r_state == S_HELD);
        w_hazard = ((r_slot.rs1 != '0) && w_busy_eff[r_slot.rs1])
                || ((r_slot.rs2 != '0) && w_busy_eff[r_slot.rs2])
                || ((r_slot.rd  != '0) && w_busy_eff[r_slot.rd])
                || ((r_slot.rd  != '0) && w_full && !w_wb_dec);
        // Flush suppresses the offer so a flushed slot can never fire
        ISSUE_VALID = w_held && !w_hazard && !MEM_WAIT && !FLUSH;
        w_fire      = ISSUE_VALID && ISSUE_READY;
        SCHED_STALL = (w_held && !w_fire) || (MEM_WAIT && w_held);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (FLUSH) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (CHECK_ACCEPT && !MEM_WAIT) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HELD;
                    end
                end
                S_HELD: begin
                    if (w_fire) begin
                        w_capture   = CHECK_ACCEPT;
                        w_state_nxt = CHECK_ACCEPT ? S_HELD : S_EMPTY;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_EMPTY;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_slot <= w_check;
            end
        end
    end

    assign ISSUE_PC     = r_slot.pc;
    assign ISSUE_OPCODE = r_slot.opcode;
    assign ISSUE_RD     = r_slot.rd;
    assign ISSUE_RS1    = r_slot.rs1;
    assign ISSUE_RS2    = r_slot.rs2;
    assign ISSUE_CSR    = r_slot.csr;
    assign ISSUE_IMM    = r_slot.imm;

endmodule

// File: tb/tb_issue_scheduler.sv
// Cycle table plus issued-instruction queue for the issue scheduler.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_issue_scheduler;

    logic        CLK;
    logic        RST_N;
    logic        FLUSH;
    logic        MEM_WAIT;
    logic        CHECK_ACCEPT;
    logic [31:0] CHECK_PC;
    logic [16:0] CHECK_OPCODE;
    logic [4:0]  CHECK_RD;
    logic [4:0]  CHECK_RS1;
    logic [4:0]  CHECK_RS2;
    logic [11:0] CHECK_CSR;
    logic [31:0] CHECK_IMM;
    logic        SCHED_STALL;
    logic        ISSUE_VALID;
    logic        ISSUE_READY;
    logic [31:0] ISSUE_PC;
    logic [16:0] ISSUE_OPCODE;
    logic [4:0]  ISSUE_RD;
    logic [4:0]  ISSUE_RS1;
    logic [4:0]  ISSUE_RS2;
    logic [11:0] ISSUE_CSR;
    logic [31:0] ISSUE_IMM;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic [31:0] BUSY_MAP;
    logic [3:0]  INFLIGHT;

    issue_scheduler #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .CHECK_ACCEPT(CHECK_ACCEPT), .CHECK_PC(CHECK_PC),
        .CHECK_OPCODE(CHECK_OPCODE), .CHECK_RD(CHECK_RD),
        .CHECK_RS1(CHECK_RS1), .CHECK_RS2(CHECK_RS2),
        .CHECK_CSR(CHECK_CSR), .CHECK_IMM(CHECK_IMM),
        .SCHED_STALL(SCHED_STALL), .ISSUE_VALID(ISSUE_VALID),
        .ISSUE_READY(ISSUE_READY), .ISSUE_PC(ISSUE_PC),
        .ISSUE_OPCODE(ISSUE_OPCODE), .ISSUE_RD(ISSUE_RD),
        .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
        .ISSUE_CSR(ISSUE_CSR), .ISSUE_IMM(ISSUE_IMM),
        .WB_VALID(WB_VALID), .WB_RD(WB_RD),
        .BUSY_MAP(BUSY_MAP), .INFLIGHT(INFLIGHT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit        acc;
        bit [4:0]  rd, rs1, rs2;
        bit        rdy, wbv;
        bit [4:0]  wbrd;
        bit        mw, fl, cap, drop;
        bit        ev, es;
        bit [31:0] eb;
        bit [3:0]  ei;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [16:0] opc;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] csr;
        logic [31:0] imm;
    } exp_t;

    vec_t tbl[$];
    exp_t sq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void v(int acc, int rd, int rs1, int rs2, int rdy,
                              int wbv, int wbrd, int mw, int fl, int cap,
                              int drop, int ev, int es, int eb, int ei);
        vec_t t;
        t.acc = 1'(acc); t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
        t.rdy = 1'(rdy); t.wbv = 1'(wbv); t.wbrd = 5'(wbrd);
        t.mw = 1'(mw); t.fl = 1'(fl); t.cap = 1'(cap); t.drop = 1'(drop);
        t.ev = 1'(ev); t.es = 1'(es); t.eb = 32'(eb); t.ei = 4'(ei);
        tbl.push_back(t);
    endfunction

    task automatic idle_inputs();
        FLUSH = 0; MEM_WAIT = 0; CHECK_ACCEPT = 0; CHECK_PC = '0;
        CHECK_OPCODE = '0; CHECK_RD = '0; CHECK_RS1 = '0; CHECK_RS2 = '0;
        CHECK_CSR = '0; CHECK_IMM = '0; ISSUE_READY = 0;
        WB_VALID = 0; WB_RD = '0;
    endtask

    initial begin
        vec_t t;
        exp_t e;
        //  acc rd rs1 rs2 rdy wbv wbrd mw fl cap drop ev es busy   inf
        // basic issue of rd5
        v(1, 5, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 'h0,   0);
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 'h0,   0);
        // RAW on x5, released by same-cycle writeback, set wins
        v(1, 5, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 'h20,  1);
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h20,  1);
        v(0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 1, 0, 'h20,  1);
        v(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 'h20,  1);
        v(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 'h0,   0);
        v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h0,   0);
        // back-to-back rd1..4, then rd6 blocked by the in-flight limit
        v(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 'h0,   0);
        v(1, 2, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 'h0,   0);
        v(1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 'h2,   1);
        v(1, 4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 'h6,   2);
        v(1, 6, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 'hE,   3);
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h1E,  4);
        v(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 'h1E,  4);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5C,  4);
        v(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 'h5C,  4);
        v(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 'h58,  3);
        v(0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 'h50,  2);
        v(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 'h40,  1);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0,   0);
        // execute not ready for three cycles
        v(1, 8, 3, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h0,   0);
        v(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0,   0);
        v(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0,   0);
        v(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h0,   0);
        v(1, 9, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 'h0,   0);
        // memory wait freezes the offer, writeback still retires x8
        v(0, 0, 0, 0, 1, 1, 8, 1, 0, 0, 0, 0, 1, 'h100, 1);
        v(1, 10, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 'h0,  0);
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 'h0,   0);
        // flush a hazarded slot, then flush a slot that would fire
        v(1, 11, 9, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h200, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 'h200, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h200, 1);
        v(1, 12, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 'h200, 1);
        v(1, 13, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 'h200, 1);
        v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h200, 1);
        v(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 'h200, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0,   0);

        idle_inputs();
        RST_N = 0;
        repeat (2) @(negedge CLK);
        chk("rst_valid", 32'(ISSUE_VALID), 32'd0);
        chk("rst_stall", 32'(SCHED_STALL), 32'd0);
        chk("rst_busy", BUSY_MAP, 32'd0);
        chk("rst_inflight", 32'(INFLIGHT), 32'd0);
        chk("rst_pc", ISSUE_PC, 32'd0);
        RST_N = 1;

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            @(posedge CLK);
            #1;
            CHECK_ACCEPT = t.acc;
            CHECK_PC     = 32'h1000 + 32'(i * 4);
            CHECK_OPCODE = 17'(i * 3 + 1);
            CHECK_RD     = t.rd;
            CHECK_RS1    = t.rs1;
            CHECK_RS2    = t.rs2;
            CHECK_CSR    = 12'(i + 100);
            CHECK_IMM    = ~CHECK_PC;
            ISSUE_READY  = t.rdy;
            WB_VALID     = t.wbv;
            WB_RD        = t.wbrd;
            MEM_WAIT     = t.mw;
            FLUSH        = t.fl;
            if (t.cap) begin
                e = '{pc: CHECK_PC, opc: CHECK_OPCODE, rd: t.rd, rs1: t.rs1,
                      rs2: t.rs2, csr: CHECK_CSR, imm: CHECK_IMM};
                sq.push_back(e);
            end
            @(negedge CLK);
            chk($sformatf("v%0d_valid", i), 32'(ISSUE_VALID), 32'(t.ev));
            chk($sformatf("v%0d_stall", i), 32'(SCHED_STALL), 32'(t.es));
            chk($sformatf("v%0d_busy", i), BUSY_MAP, t.eb);
            chk($sformatf("v%0d_inflight", i), 32'(INFLIGHT), 32'(t.ei));
            if (ISSUE_VALID) begin
                chk($sformatf("v%0d_queue_nonempty", i), 32'(sq.size() != 0), 32'd1);
                if (sq.size() != 0) begin
                    e = sq[0];
                    chk($sformatf("v%0d_pc", i), ISSUE_PC, e.pc);
                    chk($sformatf("v%0d_opc", i), 32'(ISSUE_OPCODE), 32'(e.opc));
                    chk($sformatf("v%0d_rd", i), 32'(ISSUE_RD), 32'(e.rd));
                    chk($sformatf("v%0d_rs1", i), 32'(ISSUE_RS1), 32'(e.rs1));
                    chk($sformatf("v%0d_rs2", i), 32'(ISSUE_RS2), 32'(e.rs2));
                    chk($sformatf("v%0d_csr", i), 32'(ISSUE_CSR), 32'(e.csr));
                    chk($sformatf("v%0d_imm", i), ISSUE_IMM, e.imm);
                    if (ISSUE_READY) sq.pop_front();
                end
            end
            if (t.drop && sq.size() != 0) sq.pop_front();
        end

        // reset while an offer is pending
        @(posedge CLK);
        #1;
        idle_inputs();
        CHECK_ACCEPT = 1;
        CHECK_PC     = 32'hABC0;
        CHECK_RD     = 5'd14;
        @(posedge CLK);
        #1;
        CHECK_ACCEPT = 0;
        @(negedge CLK);
        chk("mid_valid_before", 32'(ISSUE_VALID), 32'd1);
        chk("mid_pc_before", ISSUE_PC, 32'hABC0);
        #1;
        RST_N = 0;
        #1;
        chk("mid_valid", 32'(ISSUE_VALID), 32'd0);
        chk("mid_stall", 32'(SCHED_STALL), 32'd0);
        chk("mid_pc", ISSUE_PC, 32'd0);
        chk("mid_rd", 32'(ISSUE_RD), 32'd0);
        @(negedge CLK);
        RST_N = 1;
        @(negedge CLK);
        chk("post_rst_valid", 32'(ISSUE_VALID), 32'd0);
        chk("queue_drained", 32'(sq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
